// File: rtl/ram_responder_pkg.sv
// rtl/ram_responder_pkg.sv - shared state type, line geometry and offset helper for ram_responder
package ram_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_XFER
   } state_t;

   localparam int LINE_WORDS = 4;
   localparam int BEAT_W     = 2;
   // Word-index offset field is [OFS_MSB:0]; the bits above it select the line.
   localparam int OFS_MSB    = BEAT_W - 1;

   function automatic logic [BEAT_W-1:0] wrap_ofs(input logic [BEAT_W-1:0] base_ofs,
                                                  input logic [BEAT_W-1:0] beat);
      return base_ofs + beat;
   endfunction

endpackage

// File: rtl/ram_resp_array.sv
// rtl/ram_resp_array.sv - single-port word array, synchronous write and asynchronous read
module ram_resp_array #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [31:0]           i_wdata,
   output logic [31:0]           o_rdata
);

   logic [31:0] r_mem [0:(1<<ADDR_WIDTH)-1];

   // Contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - multi-cycle memory responder with critical-word-first line bursts
module ram_responder
   import ram_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs,
   input  logic        we,
   input  logic        burst,
   input  logic [31:0] addr,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        ack,
   output logic        stall
);

   localparam int CNT_W = $clog2(LATENCY + 1);

   state_t                r_state;
   state_t                w_next;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [BEAT_W-1:0]     r_beat;
   logic [BEAT_W-1:0]     r_last;
   logic [31:0]           r_dout;

   logic [ADDR_WIDTH-1:0] w_idx;
   logic [31:0]           w_rdata;
   logic                  w_last_beat;
   logic                  w_mem_we;
   logic                  w_unused;

   assign w_unused    = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};
   // Single transfers have r_beat fixed at 0, so the wrap formula yields base unchanged.
   assign w_idx       = {r_base[ADDR_WIDTH-1:BEAT_W], wrap_ofs(r_base[OFS_MSB:0], r_beat)};
   assign w_last_beat = (r_beat == r_last);
   assign w_mem_we    = (r_state == ST_XFER) && r_we;

   ram_resp_array #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_array (
      .clk    (clk),
      .i_we   (w_mem_we),
      .i_addr (w_idx),
      .i_wdata(din),
      .o_rdata(w_rdata)
   );

   always_comb begin
      w_next = r_state;
      ack    = 1'b0;
      stall  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Gate with rst so a request held during reset does not raise stall.
            if (cs && rst) begin
               stall  = 1'b1;
               w_next = (LATENCY > 1) ? ST_WAIT : ST_XFER;
            end
         end
         ST_WAIT: begin
            stall = 1'b1;
            if (r_cnt == CNT_W'(1)) begin
               w_next = ST_XFER;
            end
         end
         ST_XFER: begin
            ack   = 1'b1;
            stall = !w_last_beat;
            if (w_last_beat) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_base  <= '0;
         r_beat  <= '0;
         r_last  <= '0;
         r_dout  <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            ST_IDLE: begin
               if (cs) begin
                  r_we   <= we;
                  r_base <= addr[ADDR_WIDTH+1:2];
                  r_beat <= '0;
                  r_last <= burst ? BEAT_W'(LINE_WORDS - 1) : '0;
                  r_cnt  <= CNT_W'(LATENCY - 1);
               end
            end
            ST_WAIT: r_cnt <= r_cnt - CNT_W'(1);
            ST_XFER: begin
               r_beat <= r_beat + BEAT_W'(1);
               if (!r_we) begin
                  r_dout <= w_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   // Read beats present array data in their ack cycle; r_dout holds it afterwards.
   assign dout = ((r_state == ST_XFER) && !r_we) ? w_rdata : r_dout;

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - randomized self-checking bench against a word-array reference model
module tb_ram_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cs, we, burst;
   logic [31:0] addr, din;
   bit          sel;

   logic        cs4, cs1;
   logic [31:0] dout4, dout1, dout_m;
   logic        ack4, ack1, ack_m;
   logic        stall4, stall1, stall_m;

   int          n_chk  = 0;
   int          n_fail = 0;

   logic [31:0] mdl [2][1024];
   bit          mv  [2][1024];
   logic [31:0] ld  [2];
   bit          lk  [2];

   always #5 clk = ~clk;

   assign cs4     = cs & ~sel;
   assign cs1     = cs & sel;
   assign ack_m   = sel ? ack1   : ack4;
   assign stall_m = sel ? stall1 : stall4;
   assign dout_m  = sel ? dout1  : dout4;

   ram_responder #(.ADDR_WIDTH(10), .LATENCY(4)) dut4 (
      .clk(clk), .rst(rst_n), .cs(cs4), .we(we), .burst(burst), .addr(addr),
      .din(din), .dout(dout4), .ack(ack4), .stall(stall4)
   );

   ram_responder #(.ADDR_WIDTH(6), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst_n), .cs(cs1), .we(we), .burst(burst), .addr(addr),
      .din(din), .dout(dout1), .ack(ack1), .stall(stall1)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d t=%0t got=%h exp=%h", tag, sel ? 1 : 4, $time, got, exp);
      end
   endtask

   function automatic int widx(input logic [31:0] a);
      return sel ? int'(a[7:2]) : int'(a[11:2]);
   endfunction

   function automatic int bidx(input int base, input int k);
      return (base & ~3) | ((base + k) & 3);
   endfunction

   // Entered just after a rising edge; cycle 0 is the cycle that starts now.
   task automatic xact(input bit w, input bit b, input logic [31:0] a, input logic [127:0] wd,
                       input int rst_beats, input bit glitch);
      int nb, lat, base, k, idx;
      bit eack;
      nb   = b ? 4 : 1;
      lat  = sel ? 1 : 4;
      base = widx(a);
      cs = 1'b1; we = w; burst = b; addr = a; din = wd[31:0];
      for (int c = 0; c < lat + nb; c++) begin
         @(negedge clk);
         eack = (c >= lat);
         k    = c - lat;
         check_val("ack", 32'(ack_m), 32'(eack));
         check_val("stall", 32'(stall_m), 32'(c < lat + nb - 1));
         if (eack && !w) begin
            idx     = bidx(base, k);
            ld[sel] = mdl[sel][idx];
            lk[sel] = mv[sel][idx];
         end
         if (lk[sel]) check_val("dout", dout_m, ld[sel]);
         @(posedge clk);
         if (eack && w) begin
            idx = bidx(base, k);
            mdl[sel][idx] = wd[32*k +: 32];
            mv[sel][idx]  = 1'b1;
         end
         #1;
         if (glitch && c == 0) begin cs = 1'b0; addr = a ^ 32'h40; we = !w; end
         if (glitch && c == 1) cs = 1'b1;
         if (c == lat - 1) begin cs = 1'b1; addr = a; we = w; end
         if (eack && k + 1 < nb) din = wd[32*(k+1) +: 32];
         if (eack && rst_beats == k + 1) begin
            rst_n = 1'b0;
            @(negedge clk);
            check_val("rst_ack", 32'(ack_m), 32'd0);
            check_val("rst_stall", 32'(stall_m), 32'd0);
            check_val("rst_dout", dout_m, 32'd0);
            ld[0] = '0; ld[1] = '0; lk[0] = 1'b1; lk[1] = 1'b1;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            cs    = 1'b0;
            return;
         end
      end
      cs = 1'b0;
   endtask

   task automatic idle_check(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_val("idle_ack", 32'(ack_m), 32'd0);
         check_val("idle_stall", 32'(stall_m), 32'd0);
         if (lk[sel]) check_val("idle_dout", dout_m, ld[sel]);
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [127:0] rnd_line();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   initial begin
      logic [31:0] ra;
      rst_n = 1'b0; cs = 1'b1; we = 1'b0; burst = 1'b0; addr = 32'h10; din = '0; sel = 1'b0;
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 1024; i++) mv[s][i] = 1'b0;
      end
      for (int i = 0; i < 6; i++) begin
         #1 sel = (i % 2 == 1);
         @(negedge clk);
         check_val("rst_ack", 32'(ack_m), 32'd0);
         check_val("rst_stall", 32'(stall_m), 32'd0);
         check_val("rst_dout", dout_m, 32'd0);
         @(posedge clk);
      end
      #1;
      rst_n = 1'b1; cs = 1'b0; sel = 1'b0;
      ld[0] = '0; ld[1] = '0; lk[0] = 1'b1; lk[1] = 1'b1;

      xact(1'b1, 1'b0, 32'h10, {96'd0, 32'hDEADBEEF}, 0, 1'b0);
      xact(1'b0, 1'b0, 32'h10, '0, 0, 1'b0);
      check_val("rd_10", dout_m, 32'hDEADBEEF);

      for (int i = 0; i < 4; i++) xact(1'b1, 1'b0, 32'h40 + 32'(4*i), 128'(i + 1), 0, 1'b0);
      xact(1'b0, 1'b1, 32'h48, '0, 0, 1'b0);

      xact(1'b1, 1'b1, 32'h34, {32'hD, 32'hC, 32'hB, 32'hA}, 0, 1'b0);
      xact(1'b0, 1'b1, 32'h30, '0, 0, 1'b0);

      xact(1'b1, 1'b1, 32'h80, {32'h44, 32'h33, 32'h22, 32'h11}, 0, 1'b0);
      xact(1'b1, 1'b1, 32'h84, {32'hE4, 32'hE3, 32'hE2, 32'hE1}, 2, 1'b0);
      xact(1'b0, 1'b1, 32'h80, '0, 0, 1'b0);
      xact(1'b0, 1'b0, 32'h88, '0, 0, 1'b0);

      for (int s = 0; s < 2; s++) begin
         sel = (s == 1);
         for (int ln = 0; ln < 8; ln++) xact(1'b1, 1'b1, 32'(ln * 16), rnd_line(), 0, 1'b0);
         for (int t = 0; t < 40; t++) begin
            ra = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2);
            xact(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rnd_line(), 0, 1'b0);
            if ($urandom_range(0, 3) == 0) idle_check(1);
         end
         idle_check(2);
      end

      sel = 1'b0;
      xact(1'b0, 1'b0, 32'h10, {96'd0, 32'h5A5A_5A5A}, 0, 1'b1);
      idle_check(2);
      xact(1'b0, 1'b0, 32'h50, '0, 0, 1'b0);
      xact(1'b0, 1'b0, 32'h10, '0, 0, 1'b0);

      sel = 1'b1;
      xact(1'b0, 1'b0, 32'h24, '0, 0, 1'b0);
      idle_check(2);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
